// File: rtl/motor_pwm.sv
// H-bridge PWM driver: duty follows |velocity|, dir follows sign, and a
// braking dead-time of whole PWM periods is inserted on every reversal.
module motor_pwm #(
  parameter int PRESCALE = 1000,
  parameter int DEADTIME = 4
) (
  input  logic              cclk,
  input  logic              rst,
  input  logic              en,
  input  logic signed [7:0] velocity,
  output logic              pwm,
  output logic              dir,
  output logic              braking,
  output logic              period
);

  localparam int               PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [6:0]       CNT_MAX = 7'd126;
  localparam logic [7:0]       DT_INIT = 8'(DEADTIME - 1);

  typedef enum logic {RUN, BRAKE} state_t;

  // |v| with -128 saturated to 127 so the magnitude fits in 7 bits
  function automatic logic [6:0] sat_abs(input logic signed [7:0] v);
    if (v == 8'sh80) return 7'd127;
    return v[7] ? 7'(~v[6:0] + 7'd1) : v[6:0];
  endfunction

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [6:0]       mag_q, mag_d;
  logic [7:0]       dt_q, dt_d;
  logic             dir_q, dir_d;
  logic             braking_q, braking_d;
  logic             pwm_q, pwm_d;
  logic             period_q, period_d;
  logic             tick, boundary;

  assign tick     = (pre_q == PRE_MAX);
  assign boundary = tick && (cnt_q == CNT_MAX);
  assign pre_d    = tick ? '0 : pre_q + 1'b1;
  assign cnt_d    = !tick ? cnt_q : ((cnt_q == CNT_MAX) ? 7'd0 : cnt_q + 7'd1);

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      pre_q     <= '0;
      cnt_q     <= 7'd0;
      mag_q     <= 7'd0;
      dt_q      <= 8'd0;
      dir_q     <= 1'b0;
      braking_q <= 1'b0;
      pwm_q     <= 1'b0;
      period_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      mag_q     <= mag_d;
      dt_q      <= dt_d;
      dir_q     <= dir_d;
      braking_q <= braking_d;
      pwm_q     <= pwm_d;
      period_q  <= period_d;
    end
  end

  // Command is only looked at on the period boundary, so duty never glitches mid-period
  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    dt_d      = dt_q;
    dir_d     = dir_q;
    braking_d = braking_q;
    if (boundary) begin
      case (state_q)
        RUN: begin
          if (velocity == 8'sd0) begin
            mag_d = 7'd0;
          end else if (velocity[7] ^ dir_q) begin
            mag_d = sat_abs(velocity);
          end else begin
            mag_d     = 7'd0;
            dt_d      = DT_INIT;
            braking_d = 1'b1;
            state_d   = BRAKE;
          end
        end
        BRAKE: begin
          if (dt_q != 8'd0) begin
            dt_d = dt_q - 8'd1;
          end else begin
            if (velocity != 8'sd0) dir_d = ~velocity[7];
            mag_d     = sat_abs(velocity);
            braking_d = 1'b0;
            state_d   = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    pwm_d    = en && (state_q == RUN) && (cnt_q < mag_q);
    period_d = boundary;
  end

  assign pwm     = pwm_q;
  assign dir     = dir_q;
  assign braking = braking_q;
  assign period  = period_q;

endmodule

// File: tb/tb_motor_pwm.sv
// Directed bench for motor_pwm with PRESCALE=2, DEADTIME=2 (254 cclk per PWM period).
module tb_motor_pwm;

  logic              cclk = 1'b0;
  logic              rst  = 1'b1;
  logic              en   = 1'b1;
  logic signed [7:0] velocity = 8'sd0;
  logic              pwm, dir, braking, period;

  int checks   = 0;
  int failures = 0;

  motor_pwm #(.PRESCALE(2), .DEADTIME(2)) dut (
    .cclk(cclk), .rst(rst), .en(en), .velocity(velocity),
    .pwm(pwm), .dir(dir), .braking(braking), .period(period)
  );

  always #5 cclk = ~cclk;

  // Wait for the next period pulse (bounded), counting cycles and pwm-high samples
  task automatic wait_period(output int cyc, output int hi);
    cyc = 0; hi = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge cclk);
      cyc++;
      if (pwm) hi++;
      if (period) break;
    end
  endtask

  // One full PWM period starting just after a period pulse; optionally drops en for 10 cycles
  task automatic measure(input int off_at, output int hi, output logic brk_mid,
                         output logic dir_mid, output int early_p, output logic last_p);
    hi = 0; early_p = 0; brk_mid = 1'b0; dir_mid = 1'b0; last_p = 1'b0;
    for (int i = 0; i < 254; i++) begin
      @(negedge cclk);
      if (pwm) hi++;
      if (i == 100) begin brk_mid = braking; dir_mid = dir; end
      if (i < 253 && period) early_p++;
      if (i == 253) last_p = period;
      if (off_at >= 0 && i == off_at) en = 1'b0;
      if (off_at >= 0 && i == off_at + 10) en = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge cclk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int cyc, hi, ep; logic b, d, lp;
    velocity = 8'sd0; en = 1'b1; rst = 1'b1;
    repeat (3) @(negedge cclk);
    checks++;
    if ({pwm, dir, braking, period} !== 4'b0000) begin
      failures++; $display("FAIL reset_outputs: got %b expected 0000", {pwm, dir, braking, period});
    end
    rst = 1'b0;
    wait_period(cyc, hi);
    checks++;
    if (cyc !== 254) begin failures++; $display("FAIL reset_first_period: got %0d expected 254", cyc); end
    checks++;
    if (hi !== 0) begin failures++; $display("FAIL reset_pre_pwm: got %0d expected 0", hi); end
    for (int w = 0; w < 3; w++) begin
      measure(-1, hi, b, d, ep, lp);
      checks++;
      if (hi !== 0) begin failures++; $display("FAIL zero_duty[%0d]: got %0d expected 0", w, hi); end
      checks++;
      if ({b, d} !== 2'b00) begin failures++; $display("FAIL zero_brk_dir[%0d]: got %b expected 00", w, {b, d}); end
      checks++;
      if (ep !== 0 || lp !== 1'b1) begin failures++; $display("FAIL zero_period[%0d]: got early=%0d last=%b expected 0/1", w, ep, lp); end
    end
  endtask

  task automatic test_forward_from_reset();
    int cyc, hi, ep; logic b, d, lp;
    int   exp_hi[3] = '{0, 0, 128};
    logic exp_b[3]  = '{1'b1, 1'b1, 1'b0};
    logic exp_d[3]  = '{1'b0, 1'b0, 1'b1};
    velocity = 8'sd64;
    do_reset();
    wait_period(cyc, hi);
    checks++;
    if (cyc !== 254) begin failures++; $display("FAIL fwd_first_period: got %0d expected 254", cyc); end
    for (int w = 0; w < 3; w++) begin
      measure(-1, hi, b, d, ep, lp);
      checks++;
      if (hi !== exp_hi[w]) begin failures++; $display("FAIL fwd_duty[%0d]: got %0d expected %0d", w, hi, exp_hi[w]); end
      checks++;
      if (b !== exp_b[w]) begin failures++; $display("FAIL fwd_braking[%0d]: got %b expected %b", w, b, exp_b[w]); end
      checks++;
      if (d !== exp_d[w]) begin failures++; $display("FAIL fwd_dir[%0d]: got %b expected %b", w, d, exp_d[w]); end
      checks++;
      if (ep !== 0 || lp !== 1'b1) begin failures++; $display("FAIL fwd_period[%0d]: got early=%0d last=%b expected 0/1", w, ep, lp); end
    end
  endtask

  task automatic test_reversal();
    int hi, ep; logic b, d, lp;
    int   exp_hi[3] = '{0, 0, 100};
    logic exp_b[3]  = '{1'b1, 1'b1, 1'b0};
    logic exp_d[3]  = '{1'b1, 1'b1, 1'b0};
    velocity = 8'sd50;
    measure(-1, hi, b, d, ep, lp);
    measure(-1, hi, b, d, ep, lp);
    checks++;
    if (hi !== 100 || d !== 1'b1 || b !== 1'b0) begin
      failures++; $display("FAIL rev_steady: got duty=%0d dir=%b brk=%b expected 100/1/0", hi, d, b);
    end
    velocity = -8'sd50;
    measure(-1, hi, b, d, ep, lp);
    for (int w = 0; w < 3; w++) begin
      measure(-1, hi, b, d, ep, lp);
      checks++;
      if (hi !== exp_hi[w]) begin failures++; $display("FAIL rev_duty[%0d]: got %0d expected %0d", w, hi, exp_hi[w]); end
      checks++;
      if (b !== exp_b[w]) begin failures++; $display("FAIL rev_braking[%0d]: got %b expected %b", w, b, exp_b[w]); end
      checks++;
      if (d !== exp_d[w]) begin failures++; $display("FAIL rev_dir[%0d]: got %b expected %b", w, d, exp_d[w]); end
    end
  endtask

  task automatic test_saturation_and_zero();
    int hi, ep; logic b, d, lp;
    velocity = -8'sd128;
    measure(-1, hi, b, d, ep, lp);
    measure(-1, hi, b, d, ep, lp);
    checks++;
    if (hi !== 254) begin failures++; $display("FAIL sat_duty: got %0d expected 254", hi); end
    checks++;
    if ({b, d} !== 2'b00) begin failures++; $display("FAIL sat_brk_dir: got %b expected 00", {b, d}); end
    velocity = 8'sd0;
    measure(-1, hi, b, d, ep, lp);
    measure(-1, hi, b, d, ep, lp);
    checks++;
    if (hi !== 0) begin failures++; $display("FAIL zero_cmd_duty: got %0d expected 0", hi); end
    checks++;
    if ({b, d} !== 2'b00) begin failures++; $display("FAIL zero_cmd_brk_dir: got %b expected 00", {b, d}); end
  endtask

  task automatic test_enable_gap();
    int hi, ep; logic b, d, lp;
    velocity = 8'sd100;
    measure(-1, hi, b, d, ep, lp);
    for (int w = 0; w < 2; w++) begin
      measure(-1, hi, b, d, ep, lp);
      checks++;
      if (hi !== 0 || b !== 1'b1) begin failures++; $display("FAIL en_brake[%0d]: got duty=%0d brk=%b expected 0/1", w, hi, b); end
    end
    measure(20, hi, b, d, ep, lp);
    checks++;
    if (hi !== 190) begin failures++; $display("FAIL en_gap_duty: got %0d expected 190", hi); end
    checks++;
    if (d !== 1'b1 || ep !== 0 || lp !== 1'b1) begin
      failures++; $display("FAIL en_gap_period: got dir=%b early=%0d last=%b expected 1/0/1", d, ep, lp);
    end
    measure(-1, hi, b, d, ep, lp);
    checks++;
    if (hi !== 200) begin failures++; $display("FAIL en_restored_duty: got %0d expected 200", hi); end
  endtask

  task automatic test_reset_mid_brake();
    int hi, ep, cyc; logic b, d, lp;
    velocity = -8'sd100;
    measure(-1, hi, b, d, ep, lp);
    repeat (50) @(negedge cclk);
    checks++;
    if (braking !== 1'b1 || dir !== 1'b1 || pwm !== 1'b0) begin
      failures++; $display("FAIL brake_before_rst: got brk=%b dir=%b pwm=%b expected 1/1/0", braking, dir, pwm);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({pwm, dir, braking, period} !== 4'b0000) begin
      failures++; $display("FAIL async_rst_outputs: got %b expected 0000", {pwm, dir, braking, period});
    end
    @(negedge cclk);
    rst = 1'b0;
    velocity = 8'sd0;
    wait_period(cyc, hi);
    checks++;
    if (cyc !== 254 || hi !== 0) begin failures++; $display("FAIL post_rst_period: got cyc=%0d duty=%0d expected 254/0", cyc, hi); end
    checks++;
    if (braking !== 1'b0 || dir !== 1'b0) begin failures++; $display("FAIL post_rst_state: got brk=%b dir=%b expected 0/0", braking, dir); end
  endtask

  initial begin
    test_reset();
    test_forward_from_reset();
    test_reversal();
    test_saturation_and_zero();
    test_enable_gap();
    test_reset_mid_brake();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
